// File: rtl/mux_pkg.sv
// Shared types for the N-to-1 mux serializer: FSM state encoding and default width.
// No latency or backpressure; this package holds declarations only.
package mux_pkg;

    localparam int MUX_N = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } state_t;

endpackage

// File: rtl/mux_serializer_if.sv
// Parallel-in / serial-out bundle: master drives the word, slave (serializer) drives the stream.
// din_ready throttles the master; the serial side has no backpressure.
interface mux_serializer_if
    import mux_pkg::*;
#(
    parameter int N = MUX_N
);
    localparam int SELW = $clog2(N);

    logic [N-1:0]    din;
    logic            din_valid;
    logic            din_ready;
    logic [SELW-1:0] sel;
    logic            sout;
    logic            sout_valid;
    logic            frame_start;
    logic            frame_done;

    modport master (
        output din, din_valid,
        input  din_ready, sel, sout, sout_valid, frame_start, frame_done
    );

    modport slave (
        input  din, din_valid,
        output din_ready, sel, sout, sout_valid, frame_start, frame_done
    );

endinterface

// File: rtl/mux_n.sv
// Combinational N-to-1 bit mux; zero latency, no handshake.
// Select values beyond N-1 (non-power-of-two N) yield 0 rather than X.
module mux_n #(
    parameter int N    = 8,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    din,
    input  logic [SELW-1:0] sel,
    output logic            dout
);

    always_comb begin
        dout = 1'b0;
        if (32'(sel) < N) begin
            dout = din[sel];
        end
    end

endmodule

// File: rtl/mux_serializer.sv
// Serializes an N-bit word LSB first, exporting sel for an external lock-step mux; bit 0 appears one edge after transfer.
// din_ready is high only in IDLE and the final bit cycle; optional even-parity bit under PARITY_EN.
module mux_serializer
    import mux_pkg::*;
#(
    parameter int N = MUX_N
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_serializer_if.slave   bus
);

    localparam int              SELW = $clog2(N);
    localparam logic [SELW-1:0] LAST = SELW'(N - 1);

    state_t          state_q, state_d;
    logic [SELW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    word_q, word_d;
    logic            sout_q, sout_d;
    logic            sout_valid_q, sout_valid_d;
    logic            frame_start_q, frame_start_d;
    logic            frame_done_q, frame_done_d;

    logic            final_bit;
    logic            din_ready;
    logic            take;
    logic            mux_bit;

    // The cycle in which the last bit of the frame is on sout; a new word may land here.
    always_comb begin
`ifdef PARITY_EN
        final_bit = (state_q == PARITY);
`else
        final_bit = (state_q == SHIFT) && (cnt_q == LAST);
`endif
    end

    assign din_ready = (state_q == IDLE) || final_bit;
    assign take      = bus.din_valid && din_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
            end
            SHIFT: begin
                if (cnt_q != LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
`ifdef PARITY_EN
                    state_d = PARITY;
`else
                    state_d = IDLE;
                    cnt_d   = '0;
`endif
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A transfer always restarts at bit 0, which also gives back-to-back frames with no gap.
        if (take) begin
            state_d = SHIFT;
            cnt_d   = '0;
            word_d  = bus.din;
        end
    end

    mux_n #(
        .N    (N),
        .SELW (SELW)
    ) u_mux_n (
        .din  (word_d),
        .sel  (cnt_d),
        .dout (mux_bit)
    );

    // Outputs are precomputed from the next state so they line up with sel after the edge.
    always_comb begin
        sout_d        = 1'b0;
        sout_valid_d  = (state_d != IDLE);
        frame_start_d = take;
        frame_done_d  = 1'b0;

        unique case (state_d)
            SHIFT:   sout_d = mux_bit;
            PARITY:  sout_d = ^word_d;
            default: sout_d = 1'b0;
        endcase

`ifdef PARITY_EN
        frame_done_d = (state_d == PARITY);
`else
        frame_done_d = (state_d == SHIFT) && (cnt_d == LAST);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            word_q        <= '0;
            sout_q        <= 1'b0;
            sout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            word_q        <= word_d;
            sout_q        <= sout_d;
            sout_valid_q  <= sout_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign bus.din_ready   = din_ready;
    assign bus.sel         = cnt_q;
    assign bus.sout        = sout_q;
    assign bus.sout_valid  = sout_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_done  = frame_done_q;

endmodule
